// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single RAM transaction port: per-transaction
// round-robin grant, response steering to the owner, and a stall watchdog.
module ram_arbiter #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_txs,
    input  logic        m0_re,
    input  logic        m0_we,
    input  logic [63:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_txe,
    output logic        m0_err,
    output logic [31:0] m0_rd,

    input  logic        m1_txs,
    input  logic        m1_re,
    input  logic        m1_we,
    input  logic [63:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_txe,
    output logic        m1_err,
    output logic [31:0] m1_rd,

    output logic        ram_txs,
    output logic        ram_re,
    output logic        ram_we,
    output logic [63:0] ram_addr,
    output logic [31:0] ram_wd,
    input  logic        ram_txe,
    input  logic        ram_err,
    input  logic [31:0] ram_out,

    output logic [1:0]  grant,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a master owns the bus from the cycle after its grant until
    // the cycle after it drops txs; ram_txe/ram_err only count while BUSY.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             last_q, last_d;   // 1: m1 was served last, m0 wins a tie
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        own1;
    logic        o_txs, o_re, o_we;
    logic [63:0] o_addr;
    logic [31:0] o_wd;

    assign own1   = grant_q[1];
    assign o_txs  = own1 ? m1_txs  : m0_txs;
    assign o_re   = own1 ? m1_re   : m0_re;
    assign o_we   = own1 ? m1_we   : m0_we;
    assign o_addr = own1 ? m1_addr : m0_addr;
    assign o_wd   = own1 ? m1_wd   : m0_wd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ram_txs  = 1'b0;
        ram_re   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_wd   = '0;
        m0_txe   = 1'b0;
        m0_err   = 1'b0;
        m0_rd    = '0;
        m1_txe   = 1'b0;
        m1_err   = 1'b0;
        m1_rd    = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (m0_txs && (!m1_txs || last_q)) begin
                    state_d = S_BUSY;
                    grant_d = 2'b01;
                    last_d  = 1'b0;
                end else if (m1_txs) begin
                    state_d = S_BUSY;
                    grant_d = 2'b10;
                    last_d  = 1'b1;
                end
            end

            S_BUSY: begin
                ram_txs  = o_txs;
                ram_re   = o_re;
                ram_we   = o_we;
                ram_addr = o_addr;
                ram_wd   = o_wd;
                if (own1) begin
                    m1_txe = ram_txe;
                    m1_err = ram_err;
                    m1_rd  = ram_out;
                end else begin
                    m0_txe = ram_txe;
                    m0_err = ram_err;
                    m0_rd  = ram_out;
                end

                // Release takes priority over a watchdog expiry in the same cycle.
                if (!o_txs) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    cnt_d   = '0;
                end else if ((TIMEOUT > 0) && (o_re || o_we) && !ram_txe) begin
                    if (cnt_q == LIMIT) begin
                        state_d = S_ABORT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            S_ABORT: begin
                cnt_d = '0;
                if (own1) begin
                    m1_txe = 1'b1;
                    m1_err = 1'b1;
                end else begin
                    m0_txe = 1'b1;
                    m0_err = 1'b1;
                end
                if (!o_txs) begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                end
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                cnt_d   = '0;
            end
        endcase
    end

    assign grant     = grant_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-level
// transaction model of the two-master RAM arbiter.
module tb_ram_arbiter;

    localparam int TO = 8;

    logic        clk, rst_n;
    logic        m0_txs, m0_re, m0_we;
    logic [63:0] m0_addr;
    logic [31:0] m0_wd;
    logic        m0_txe, m0_err;
    logic [31:0] m0_rd;
    logic        m1_txs, m1_re, m1_we;
    logic [63:0] m1_addr;
    logic [31:0] m1_wd;
    logic        m1_txe, m1_err;
    logic [31:0] m1_rd;
    logic        ram_txs, ram_re, ram_we;
    logic [63:0] ram_addr;
    logic [31:0] ram_wd;
    logic        ram_txe, ram_err;
    logic [31:0] ram_out;
    logic [1:0]  grant;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    // model: owner 0 = none, 1 = m0, 2 = m1
    int mdl_owner;
    bit mdl_abort;
    int mdl_stall;
    int mdl_prev;
    int mdl_aborts;

    ram_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_txs(m0_txs), .m0_re(m0_re), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_txe(m0_txe), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_txs(m1_txs), .m1_re(m1_re), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_txe(m1_txe), .m1_err(m1_err), .m1_rd(m1_rd),
        .ram_txs(ram_txs), .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wd(ram_wd),
        .ram_txe(ram_txe), .ram_err(ram_err), .ram_out(ram_out),
        .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        m0_txs = 0; m0_re = 0; m0_we = 0; m0_addr = '0; m0_wd = '0;
        m1_txs = 0; m1_re = 0; m1_we = 0; m1_addr = '0; m1_wd = '0;
        ram_txe = 0; ram_err = 0; ram_out = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    function automatic logic [169:0] dut_out();
        return {ram_txs, ram_re, ram_we, ram_addr, ram_wd,
                m0_txe, m0_err, m0_rd, m1_txe, m1_err, m1_rd, grant, busy};
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (dut_out() !== 170'd0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0", dut_out());
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_grant actual=%b required=000", {grant, busy});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        m0_txs = 1; m0_re = 1; m0_addr = 64'h10;
        @(negedge clk);
        checks++;
        if (ram_txs !== 1'b0) begin
            failures++;
            $display("FAIL read_latency ram_txs=%b required=0", ram_txs);
        end
        cyc();
        @(negedge clk);
        checks++;
        if ({ram_txs, ram_re, ram_we, ram_addr} !== {1'b1, 1'b1, 1'b0, 64'h10}) begin
            failures++;
            $display("FAIL read_issue actual=%b%b%b %h", ram_txs, ram_re, ram_we, ram_addr);
        end
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL read_grant actual=%b required=01", grant);
        end
        cyc();
        cyc();
        ram_txe = 1; ram_out = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if ({m0_txe, m0_rd} !== {1'b1, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL read_data m0_txe=%b m0_rd=%h required 1 deadbeef", m0_txe, m0_rd);
        end
        checks++;
        if ({m1_txe, m1_err, m1_rd} !== 34'd0) begin
            failures++;
            $display("FAIL read_m1_quiet m1_txe=%b m1_rd=%h required 0", m1_txe, m1_rd);
        end
        cyc();
        clear_inputs();
        cyc();
        @(negedge clk);
        checks++;
        if ({grant, busy} !== 3'b000) begin
            failures++;
            $display("FAIL read_release grant/busy=%b required=000", {grant, busy});
        end
    endtask

    task automatic test_tie_rr();
        do_reset();
        m0_txs = 1; m1_txs = 1;
        cyc();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL tie_first grant=%b required=01", grant);
        end
        cyc();
        m0_txs = 0;
        cyc();
        @(negedge clk);
        checks++;
        if ({grant, busy, ram_txs} !== 4'b0000) begin
            failures++;
            $display("FAIL tie_gap grant/busy/txs=%b required=0000", {grant, busy, ram_txs});
        end
        cyc();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin
            failures++;
            $display("FAIL tie_second grant=%b required=10", grant);
        end
        m1_txs = 0;
        cyc();
        m0_txs = 1; m1_txs = 1;
        cyc();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL tie_rr grant=%b required=01", grant);
        end
        clear_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_no_preempt();
        m0_txs = 1; m0_addr = 64'h1000;
        cyc();
        m1_txs = 1; m1_re = 1; m1_addr = 64'hAAAA_0000; ram_txe = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({grant, ram_addr, m1_txe, m0_txe} !== {2'b01, 64'h1000, 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL hold cycle=%0d grant=%b ram_addr=%h m1_txe=%b m0_txe=%b", i, grant, ram_addr, m1_txe, m0_txe);
            end
            cyc();
        end
        m0_txs = 0;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if ({grant, ram_addr, m1_txe} !== {2'b10, 64'hAAAA_0000, 1'b1}) begin
            failures++;
            $display("FAIL handover grant=%b ram_addr=%h m1_txe=%b", grant, ram_addr, m1_txe);
        end
        clear_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_timeout();
        m1_txs = 1; m1_re = 1; m1_addr = 64'h20;
        cyc();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_txs, m1_err, grant} !== {1'b1, 1'b0, 2'b10}) begin
                failures++;
                $display("FAIL wd_pre cycle=%0d ram_txs=%b m1_err=%b grant=%b", i, ram_txs, m1_err, grant);
            end
            cyc();
        end
        ram_out = 32'hFFFF_FFFF; ram_err = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ram_txs, ram_re, ram_addr, m1_txe, m1_err, m1_rd, grant, busy, m0_err}
                !== {1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 32'd0, 2'b10, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL wd_abort cycle=%0d ram_txs=%b m1_txe=%b m1_err=%b m1_rd=%h grant=%b busy=%b",
                         i, ram_txs, m1_txe, m1_err, m1_rd, grant, busy);
            end
            cyc();
        end
        clear_inputs();
        cyc();
        @(negedge clk);
        checks++;
        if ({grant, busy, m1_txe, m1_err} !== 5'b00000) begin
            failures++;
            $display("FAIL wd_exit grant=%b busy=%b m1_txe=%b m1_err=%b required 0", grant, busy, m1_txe, m1_err);
        end
    endtask

    task automatic test_err();
        m0_txs = 1; m0_we = 1; m0_addr = 64'h30; m0_wd = 32'h12345678;
        cyc();
        @(negedge clk);
        checks++;
        if ({ram_txs, ram_we, ram_wd} !== {1'b1, 1'b1, 32'h12345678}) begin
            failures++;
            $display("FAIL err_write ram_txs=%b ram_we=%b ram_wd=%h", ram_txs, ram_we, ram_wd);
        end
        cyc();
        ram_err = 1;
        @(negedge clk);
        checks++;
        if ({m0_err, m1_err} !== 2'b10) begin
            failures++;
            $display("FAIL err_pass m0_err=%b m1_err=%b required 1 0", m0_err, m1_err);
        end
        cyc();
        ram_err = 0;
        @(negedge clk);
        checks++;
        if ({m0_err, m0_txe, ram_txs, grant, busy} !== {1'b0, 1'b0, 1'b1, 2'b01, 1'b1}) begin
            failures++;
            $display("FAIL err_no_abort m0_err=%b m0_txe=%b ram_txs=%b grant=%b", m0_err, m0_txe, ram_txs, grant);
        end
        ram_txe = 1;
        cyc();
        clear_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_async_reset();
        m0_txs = 1; m0_re = 1; m0_addr = 64'h40;
        cyc();
        @(negedge clk);
        checks++;
        if ({busy, ram_txs} !== 2'b11) begin
            failures++;
            $display("FAIL areset_pre busy=%b ram_txs=%b required 11", busy, ram_txs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_txs, busy, grant} !== 4'b0000) begin
            failures++;
            $display("FAIL areset_drop ram_txs=%b busy=%b grant=%b required 0", ram_txs, busy, grant);
        end
        m1_txs = 1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin
            failures++;
            $display("FAIL areset_tie grant=%b required=01", grant);
        end
        clear_inputs();
        cyc();
        cyc();
    endtask

    // Transaction-level model: advance one clock using the inputs seen at the edge.
    task automatic model_step();
        logic o_txs, o_req;
        if (mdl_owner == 0) begin
            mdl_stall = 0;
            mdl_abort = 0;
            if (m0_txs && (!m1_txs || mdl_prev == 2)) begin
                mdl_owner = 1; mdl_prev = 1;
            end else if (m1_txs) begin
                mdl_owner = 2; mdl_prev = 2;
            end
        end else begin
            o_txs = (mdl_owner == 1) ? m0_txs : m1_txs;
            o_req = (mdl_owner == 1) ? (m0_re | m0_we) : (m1_re | m1_we);
            if (!o_txs) begin
                mdl_owner = 0; mdl_abort = 0; mdl_stall = 0;
            end else if (!mdl_abort) begin
                if (o_req && !ram_txe) begin
                    mdl_stall++;
                    if (mdl_stall == TO) begin
                        mdl_abort = 1; mdl_stall = 0; mdl_aborts++;
                    end
                end else begin
                    mdl_stall = 0;
                end
            end
        end
    endtask

    function automatic logic [169:0] model_out();
        logic rt, rr, rw, t0, e0, t1, e1, b;
        logic [63:0] ra;
        logic [31:0] rwd, d0, d1;
        logic [1:0] g;
        rt = 0; rr = 0; rw = 0; ra = '0; rwd = '0;
        t0 = 0; e0 = 0; d0 = '0; t1 = 0; e1 = 0; d1 = '0;
        g = (mdl_owner == 1) ? 2'b01 : (mdl_owner == 2) ? 2'b10 : 2'b00;
        b = (mdl_owner != 0);
        if (mdl_owner == 1 && !mdl_abort) begin
            rt = m0_txs; rr = m0_re; rw = m0_we; ra = m0_addr; rwd = m0_wd;
            t0 = ram_txe; e0 = ram_err; d0 = ram_out;
        end else if (mdl_owner == 2 && !mdl_abort) begin
            rt = m1_txs; rr = m1_re; rw = m1_we; ra = m1_addr; rwd = m1_wd;
            t1 = ram_txe; e1 = ram_err; d1 = ram_out;
        end else if (mdl_owner == 1) begin
            t0 = 1; e0 = 1;
        end else if (mdl_owner == 2) begin
            t1 = 1; e1 = 1;
        end
        return {rt, rr, rw, ra, rwd, t0, e0, d0, t1, e1, d1, g, b};
    endfunction

    task automatic drive_random(input bit heavy);
        if (m0_txs) begin
            if ($urandom_range(0, 15) == 0) m0_txs = 0;
        end else if ($urandom_range(0, 3) == 0) m0_txs = 1;
        if (m1_txs) begin
            if ($urandom_range(0, 15) == 0) m1_txs = 0;
        end else if ($urandom_range(0, 3) == 0) m1_txs = 1;
        m0_re = ($urandom_range(0, 3) != 0); m0_we = ($urandom_range(0, 1) == 0);
        m1_re = ($urandom_range(0, 3) != 0); m1_we = ($urandom_range(0, 1) == 0);
        m0_addr = {$urandom, $urandom}; m0_wd = $urandom;
        m1_addr = {$urandom, $urandom}; m1_wd = $urandom;
        ram_txe = heavy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
        ram_err = ($urandom_range(0, 9) == 0);
        ram_out = $urandom;
    endtask

    task automatic test_random();
        logic [169:0] exp_v;
        bit heavy;
        do_reset();
        mdl_owner = 0; mdl_abort = 0; mdl_stall = 0; mdl_prev = 2; mdl_aborts = 0;
        heavy = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) heavy = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            model_step();
            #1;
            drive_random(heavy);
            @(negedge clk);
            exp_v = model_out();
            checks++;
            if (dut_out() !== exp_v) begin
                failures++;
                $display("FAIL random cycle=%0d actual=%h required=%h", i, dut_out(), exp_v);
            end
        end
        $display("random run: %0d watchdog aborts modelled", mdl_aborts);
        clear_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_read();
        test_tie_rr();
        test_no_preempt();
        test_timeout();
        test_err();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
